alu_exec_stage: RTL and testbench

- Execute/write-back stage directly downstream of the decoder and wrapped around the 16 x 20-bit register file.
- Accepts one decoded instruction per valid/ready handshake and drives the file's two combinational read ports.
- Computes a 20-bit result, with single-cycle ALU ops and an iterative shift-add multiply.
- Returns the result through the file's write port (WE, DstAddr, input1).

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_exec_stage_seq_multiplier.sv | 70 +++++++
 rtl/alu_exec_stage.sv | 207 ++++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and default widths for alu_exec_stage.
// Optional flag outputs are enabled by defining ALU_FLAGS_EN.
package alu_pkg;

    localparam int unsigned DATA_W_DEF = 20;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned OP_W_DEF   = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_LDI  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_exec_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles
// after start; done and product are valid combinationally in the final cycle.
module seq_multiplier #(
    parameter int unsigned DATA_W = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic [DATA_W-1:0] partial;
    logic              last;

    // The final partial sum is exposed directly so the caller saves a cycle.
    assign partial = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign last    = run_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign done    = last;
    assign product = partial;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/write-back stage around the 16 x 20-bit register file.
// Define ALU_FLAGS_EN to add registered flag_z/flag_c outputs.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [ADDR_W-1:0] in_src1,
    input  logic [ADDR_W-1:0] in_src2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] rf_src1_addr,
    output logic [ADDR_W-1:0] rf_src2_addr,
    input  logic [DATA_W-1:0] rf_src1_data,
    input  logic [DATA_W-1:0] rf_src2_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dst_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
`ifdef ALU_FLAGS_EN
    output logic              flag_z,
    output logic              flag_c,
`endif
    output logic              done
);

    alu_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d, src1_q, src1_d, src2_q, src2_d;
    logic [DATA_W-1:0] imm_q, imm_d, result_q, result_d;
    logic [DATA_W-1:0] alu_res, mul_product;
    logic              mul_start, mul_done;
    logic [4:0]        shamt;

    assign shamt = rf_src2_data[4:0];

`ifdef ALU_FLAGS_EN
    logic              alu_c, carry_q, carry_d;
    logic              flag_z_q, flag_z_d, flag_c_q, flag_c_d;
    logic [DATA_W:0]   add_ext, sub_ext, addi_ext, shl_ext, shr_ext;

    // Extra bit carries carry/borrow; for shifts it holds the last bit shifted out.
    assign add_ext  = {1'b0, rf_src1_data} + {1'b0, rf_src2_data};
    assign sub_ext  = {1'b0, rf_src1_data} - {1'b0, rf_src2_data};
    assign addi_ext = {1'b0, rf_src1_data} + {1'b0, imm_q};
    assign shl_ext  = {1'b0, rf_src1_data} << shamt;
    assign shr_ext  = {rf_src1_data, 1'b0} >> shamt;

    always_comb begin
        alu_c = 1'b0;
        case (op_q)
            OP_W'(OP_ADD):  alu_c = add_ext[DATA_W];
            OP_W'(OP_SUB):  alu_c = sub_ext[DATA_W];
            OP_W'(OP_ADDI): alu_c = addi_ext[DATA_W];
            OP_W'(OP_SHL):  alu_c = shl_ext[DATA_W];
            OP_W'(OP_SHR):  alu_c = shr_ext[0];
            default:        alu_c = 1'b0;
        endcase
    end
`endif

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_W'(OP_AND):  alu_res = rf_src1_data & rf_src2_data;
            OP_W'(OP_OR):   alu_res = rf_src1_data | rf_src2_data;
            OP_W'(OP_XOR):  alu_res = rf_src1_data ^ rf_src2_data;
            OP_W'(OP_LDI):  alu_res = imm_q;
`ifdef ALU_FLAGS_EN
            OP_W'(OP_ADD):  alu_res = add_ext[DATA_W-1:0];
            OP_W'(OP_SUB):  alu_res = sub_ext[DATA_W-1:0];
            OP_W'(OP_ADDI): alu_res = addi_ext[DATA_W-1:0];
            OP_W'(OP_SHL):  alu_res = shl_ext[DATA_W-1:0];
            OP_W'(OP_SHR):  alu_res = shr_ext[DATA_W:1];
`else
            OP_W'(OP_ADD):  alu_res = rf_src1_data + rf_src2_data;
            OP_W'(OP_SUB):  alu_res = rf_src1_data - rf_src2_data;
            OP_W'(OP_ADDI): alu_res = rf_src1_data + imm_q;
            OP_W'(OP_SHL):  alu_res = rf_src1_data << shamt;
            OP_W'(OP_SHR):  alu_res = rf_src1_data >> shamt;
`endif
            default:        alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        imm_d     = imm_q;
        result_d  = result_q;
        mul_start = 1'b0;
`ifdef ALU_FLAGS_EN
        carry_d   = carry_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    dst_d   = in_dst;
                    src1_d  = in_src1;
                    src2_d  = in_src2;
                    imm_d   = in_imm;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_q == OP_W'(OP_MUL)) begin
                    mul_start = 1'b1;
                    state_d   = MUL;
`ifdef ALU_FLAGS_EN
                    carry_d   = 1'b0;
`endif
                end else begin
                    result_d = alu_res;
                    state_d  = WB;
`ifdef ALU_FLAGS_EN
                    carry_d  = alu_c;
`endif
                end
            end
            MUL: begin
                if (mul_done) begin
                    result_d = mul_product;
                    state_d  = WB;
                end
            end
            WB: begin
                state_d = IDLE;
`ifdef ALU_FLAGS_EN
                if (op_q <= OP_W'(OP_LDI)) begin
                    flag_z_d = (result_q == '0);
                    flag_c_d = carry_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            imm_q    <= '0;
            result_q <= '0;
`ifdef ALU_FLAGS_EN
            carry_q  <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            imm_q    <= imm_d;
            result_q <= result_d;
`ifdef ALU_FLAGS_EN
            carry_q  <= carry_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
`endif
        end
    end

    seq_multiplier #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (rf_src1_data),
        .b       (rf_src2_data),
        .done    (mul_done),
        .product (mul_product)
    );

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == WB);
    assign rf_we        = (state_q == WB) && (op_q <= OP_W'(OP_LDI));
    assign rf_dst_addr  = dst_q;
    assign rf_wdata     = result_q;
    assign rf_src1_addr = src1_q;
    assign rf_src2_addr = src2_q;
`ifdef ALU_FLAGS_EN
    assign flag_z       = flag_z_q;
    assign flag_c       = flag_c_q;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a register-file model and a
// scoreboard of expected write-backs (timing, address, data, optional flags).
module tb_alu_exec_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [3:0]  in_dst = '0;
    logic [3:0]  in_src1 = '0;
    logic [3:0]  in_src2 = '0;
    logic [19:0] in_imm = '0;
    logic [3:0]  rf_src1_addr, rf_src2_addr, rf_dst_addr;
    logic [19:0] rf_src1_data, rf_src2_data, rf_wdata;
    logic        rf_we, busy, done;
`ifdef ALU_FLAGS_EN
    logic        flag_z, flag_c;
    logic        fz_m = 1'b0;
    logic        fc_m = 1'b0;
    logic        fchk = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  dst;
        logic [19:0] data;
        int unsigned wb_edge;
        logic        upd;
        logic        z;
        logic        c;
    } sb_t;

    sb_t         sb[$];
    logic [19:0] rf   [16] = '{default: '0};
    logic [19:0] arch [16] = '{default: '0};
    logic        pl_en = 1'b0;
    logic [3:0]  pl_addr = '0;
    logic [19:0] pl_data = '0;
    int unsigned edges = 0;
    int          total = 0;
    int          bad = 0;
    int unsigned acc1, acc2;

    alu_exec_stage #(
        .DATA_W(20),
        .ADDR_W(4),
        .OP_W(4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_dst       (in_dst),
        .in_src1      (in_src1),
        .in_src2      (in_src2),
        .in_imm       (in_imm),
        .rf_src1_addr (rf_src1_addr),
        .rf_src2_addr (rf_src2_addr),
        .rf_src1_data (rf_src1_data),
        .rf_src2_data (rf_src2_data),
        .rf_we        (rf_we),
        .rf_dst_addr  (rf_dst_addr),
        .rf_wdata     (rf_wdata),
        .busy         (busy),
`ifdef ALU_FLAGS_EN
        .flag_z       (flag_z),
        .flag_c       (flag_c),
`endif
        .done         (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edges <= edges + 1;

    // Register file: combinational reads, write at the end of the WE cycle.
    always @(posedge clock) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (rf_we) rf[rf_dst_addr] <= rf_wdata;
    end
    assign rf_src1_data = rf[rf_src1_addr];
    assign rf_src2_data = rf[rf_src2_addr];

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {carry/borrow/last-bit-out, result}.
    function automatic logic [20:0] model(input logic [3:0] op, input logic [19:0] a,
                                          input logic [19:0] b, input logic [19:0] imm);
        int sh;
        logic [39:0] p;
        sh = int'(b[4:0]);
        case (op)
            4'd0: model = {1'b0, a} + {1'b0, b};
            4'd1: model = {(a < b), a - b};
            4'd2: model = {1'b0, a & b};
            4'd3: model = {1'b0, a | b};
            4'd4: model = {1'b0, a ^ b};
            4'd5: model = {1'b0, a} + {1'b0, imm};
            4'd6: begin
                if (sh == 0) model = {1'b0, a};
                else if (sh > 20) model = '0;
                else model = {a[20-sh], a << sh};
            end
            4'd7: begin
                if (sh == 0) model = {1'b0, a};
                else if (sh > 20) model = '0;
                else model = {a[sh-1], a >> sh};
            end
            4'd8: begin
                p = {20'b0, a} * {20'b0, b};
                model = {1'b0, p[19:0]};
            end
            4'd9: model = {1'b0, imm};
            default: model = '0;
        endcase
    endfunction

    task automatic preload(input logic [3:0] addr, input logic [19:0] data);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        arch[addr] = data;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [19:0] imm, input bit push,
                         input bit hold, output int unsigned acc);
        sb_t e;
        logic [20:0] r;
        int n;
        @(negedge clock);
        in_op = op; in_dst = dst; in_src1 = s1; in_src2 = s2; in_imm = imm; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("accept_wait", (n < 200), 1'b1);
        acc = edges + 1;
        if (push) begin
            r = model(op, arch[s1], arch[s2], imm);
            e.we = (op <= 4'd9);
            e.dst = dst;
            e.data = r[19:0];
            e.wb_edge = acc + ((op == 4'd8) ? 21 : 1);
            e.upd = (op <= 4'd9);
            e.z = (r[19:0] == 20'd0);
            e.c = r[20];
            if (e.we) arch[dst] = r[19:0];
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("drain", sb.size(), 0);
        @(negedge clock);
        @(negedge clock);
    endtask

    // Output monitor: each done pulse retires exactly one scoreboard entry.
    always @(negedge clock) begin
        sb_t e;
        if (reset_n) begin
`ifdef ALU_FLAGS_EN
            if (fchk) begin
                check("flag_z", flag_z, fz_m);
                check("flag_c", flag_c, fc_m);
                fchk = 1'b0;
            end
`endif
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("wb_cycle", edges, e.wb_edge);
                    check("rf_we", rf_we, e.we);
                    if (e.we) begin
                        check("rf_dst_addr", rf_dst_addr, e.dst);
                        check("rf_wdata", rf_wdata, e.data);
                    end
`ifdef ALU_FLAGS_EN
                    if (e.upd) begin
                        fz_m = e.z;
                        fc_m = e.c;
                    end
                    fchk = 1'b1;
`endif
                end
            end else begin
                check("we_without_done", rf_we, 1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_n = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_wdata", rf_wdata, 20'd0);
        check("rst_dst", rf_dst_addr, 4'd0);
        check("rst_src1", rf_src1_addr, 4'd0);
        check("rst_src2", rf_src2_addr, 4'd0);
        preload(4'd1, 20'd5);
        preload(4'd2, 20'd3);
        @(negedge clock);
        reset_n = 1'b1;

        issue(4'd0, 4'd3, 4'd1, 4'd2, 20'd0, 1, 0, acc1);      // ADD r3 = 5 + 3
        wait_idle();
        issue(4'd1, 4'd4, 4'd2, 4'd1, 20'd0, 1, 0, acc1);      // SUB r4 = 3 - 5
        issue(4'd2, 4'd6, 4'd1, 4'd2, 20'd0, 1, 0, acc1);
        issue(4'd3, 4'd7, 4'd1, 4'd4, 20'd0, 1, 0, acc1);
        issue(4'd4, 4'd8, 4'd4, 4'd2, 20'd0, 1, 0, acc1);
        issue(4'd5, 4'd9, 4'd1, 4'd0, 20'hFFFFF, 1, 0, acc1);  // ADDI with carry out
        wait_idle();

        issue(4'd9, 4'd1, 4'd0, 4'd0, 20'h00123, 1, 0, acc1);
        issue(4'd9, 4'd2, 4'd0, 4'd0, 20'h00045, 1, 0, acc1);
        issue(4'd8, 4'd10, 4'd1, 4'd2, 20'd0, 1, 0, acc1);     // MUL, in_valid pulsed mid-op
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            check("mul_in_ready", in_ready, 1'b0);
            check("mul_busy", busy, 1'b1);
            if (i == 5) begin
                in_op = 4'd9; in_dst = 4'd7; in_imm = 20'h12345; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        wait_idle();
        issue(4'd9, 4'd11, 4'd0, 4'd0, 20'hFFFFF, 1, 0, acc1);
        issue(4'd8, 4'd12, 4'd11, 4'd11, 20'd0, 1, 0, acc1);
        wait_idle();

        issue(4'd9, 4'd1, 4'd0, 4'd0, 20'd1, 1, 0, acc1);
        issue(4'd9, 4'd2, 4'd0, 4'd0, 20'd19, 1, 0, acc1);
        issue(4'd6, 4'd11, 4'd1, 4'd2, 20'd0, 1, 0, acc1);     // 1 << 19
        issue(4'd9, 4'd3, 4'd0, 4'd0, 20'd20, 1, 0, acc1);
        issue(4'd6, 4'd12, 4'd1, 4'd3, 20'd0, 1, 0, acc1);     // 1 << 20
        issue(4'd7, 4'd13, 4'd11, 4'd2, 20'd0, 1, 0, acc1);    // 0x80000 >> 19
        issue(4'd7, 4'd14, 4'd11, 4'd0, 20'd0, 1, 0, acc1);    // shift by 0
        issue(4'd9, 4'd3, 4'd0, 4'd0, 20'd31, 1, 0, acc1);
        issue(4'd7, 4'd14, 4'd11, 4'd3, 20'd0, 1, 0, acc1);    // shift by 31
        wait_idle();

        issue(4'd9, 4'd1, 4'd0, 4'd0, 20'hABCDE, 1, 1, acc1);  // in_valid held high
        issue(4'd0, 4'd2, 4'd1, 4'd1, 20'd0, 1, 0, acc2);
        check("b2b_accept_gap", acc2 - acc1, 3);
        issue(4'd0, 4'd2, 4'd2, 4'd1, 20'd0, 1, 0, acc1);      // src == dst
        wait_idle();

        issue(4'd9, 4'd5, 4'd0, 4'd0, 20'h11111, 1, 0, acc1);
        wait_idle();
        issue(4'd8, 4'd5, 4'd1, 4'd2, 20'd0, 0, 0, acc1);      // abandoned by reset
        repeat (10) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rf_we", rf_we, 1'b0);
        check("mid_rst_wdata", rf_wdata, 20'd0);
        check("mid_rst_dst", rf_dst_addr, 4'd0);
`ifdef ALU_FLAGS_EN
        fz_m = 1'b0;
        fc_m = 1'b0;
        check("mid_rst_flag_z", flag_z, 1'b0);
        check("mid_rst_flag_c", flag_c, 1'b0);
`endif
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (30) @(negedge clock);
        check("post_rst_r5", rf[5], arch[5]);
        issue(4'd12, 4'd6, 4'd1, 4'd2, 20'd0, 1, 0, acc1);     // NOP
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            check($sformatf("rf_final_r%0d", i), rf[i], arch[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
